uart_rx_core: RTL and testbench
===============================

UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4167, meaning clock cycles per bit (40 MHz, 9600 baud); legal range 8..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning receive FIFO entries; power of two, 2..32.
REQ-003 SHALL have port clk  input  1  the single clock; all logic in this domain.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port rx  input  1  serial line from pad; idles high; asynchronous to clk.
REQ-006 SHALL have port rx_data  output  8  FIFO head byte.
REQ-007 SHALL have port rx_valid  output  1  FIFO not empty.
REQ-008 SHALL have port rx_ready  input  1  consumer pops the head when rx_valid && rx_ready.
REQ-009 SHALL have port frame_err  output  1  sticky; stop bit sampled low.
REQ-010 SHALL have port overrun  output  1  sticky; byte completed while FIFO full.
REQ-011 SHALL have port clear  input  1  one-cycle pulse; clears both sticky flags and empties FIFO.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer (reset value 1); all decoding uses the synchronized signal.
REQ-014 SHALL implement states IDLE, START, DATA, STOP.
REQ-015 IDLE -> START on a synchronized falling edge; bit counter loaded with CLKS_PER_BIT/2 - 1.
REQ-016 START: at mid-bit, line low -> DATA; line high -> IDLE (glitch rejected, nothing written, no flag).
REQ-017 DATA: 8 bits sampled at mid-bit, spaced CLKS_PER_BIT apart, LSB first, shifted into an 8-bit register.
REQ-018 STOP: mid-bit sample; high -> byte written to FIFO; low -> frame_err set and byte discarded; both cases -> IDLE the next cycle.
REQ-019 Byte write to a full FIFO SHALL be dropped and set overrun; FIFO contents unchanged.
REQ-020 rx_valid SHALL rise the cycle after the STOP mid-bit sample (write latency 1 clk).
REQ-021 Simultaneous push and pop on a full FIFO SHALL succeed (pop frees the slot, no overrun).
REQ-022 rx_data SHALL stay stable while rx_valid && !rx_ready.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with an extra bit to distinguish full from empty.
REQ-024 clear SHALL win over a same-cycle flag set or push; an in-progress frame continues and is pushed normally.
REQ-025 Line held low (break) after a frame error SHALL NOT start a new frame until the line has returned high.

Reset
REQ-026 On rst_n low: state IDLE, FIFO empty, rx_valid 0, rx_data 0, frame_err 0, overrun 0, busy 0, synchronizer 1.
REQ-027 Reset mid-frame SHALL abandon the frame without a FIFO write; after release, reception resumes on the next falling edge.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: a parity state PARITY is inserted between DATA and STOP; even parity is checked; mismatch sets a sticky output parity_err (1 bit, cleared by clear and reset) and discards the byte.
REQ-029 Macro UART_RX_PARITY_EN undefined: the frame is 8N1, no PARITY state, and the parity_err port is absent.

Structure
REQ-030 Shared package uart_pkg SHALL hold the state enum, the data width constant (8), and the idle line level.
REQ-031 FIFO SHALL be a sub-module uart_rx_fifo (parameters DEPTH and WIDTH; ports push, pop, din, dout, full, empty, flush).

Verification
REQ-032 CLKS_PER_BIT=16: send 0x3D 8N1 -> rx_valid after STOP mid-bit + 1 clk, rx_data=0x3D, no flags.
REQ-033 8-clk low pulse on idle line -> busy returns to 0, FIFO still empty, no flags.
REQ-034 Send 0x0F with stop bit low -> frame_err=1, FIFO empty; pulse clear -> frame_err=0.
REQ-035 rx_ready=0, send 9 bytes 0x01..0x09 (depth 8) -> overrun=1; pop order 0x01..0x08.
REQ-036 Assert rst_n low during DATA of 0xA5 -> no write; then send 0x5A -> rx_data=0x5A.
REQ-037 UART_RX_PARITY_EN defined: send 0x07 with parity bit 0 -> parity_err=1 and no write; send 0x07 with parity bit 1 -> byte accepted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, data width, idle line level.
// UART_RX_PARITY_EN adds the PARITY state used by the even-parity frame format.
package uart_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam logic        IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: power-of-two depth, pointers carry one extra wrap bit so full and empty differ.
// A pop on a full FIFO frees the slot for a same-cycle push; flush empties it and wins over push.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PTR_ONE;
      if (do_pop)  rd_d = rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM, sticky error flags and a receive FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity_err output; default is 8N1.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4167,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       clear,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_BIT = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_W - 1);

  rx_state_e         state_q, state_d;
  logic              sync1_q, sync2_q, prev_q;
  logic [15:0]       cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              push_q, push_d;
  logic              busy_q, busy_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              fall, mid, frame_set;
  logic              fifo_full, fifo_empty, fifo_pop;
`ifdef UART_RX_PARITY_EN
  logic              par_bad_q, par_bad_d;
  logic              parity_err_q, parity_err_d;
`endif

  // Edge detection needs a high-to-low transition, so a held break never restarts a frame.
  assign fall     = prev_q && (sync2_q != IDLE_LEVEL);
  assign mid      = (cnt_q == '0);
  assign rx_valid = !fifo_empty;
  assign fifo_pop = rx_ready && rx_valid;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push_d    = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = clear ? 1'b0 : parity_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d = ST_START;
          cnt_d   = HALF_BIT;
        end
      end
      ST_START: begin
        if (!mid) begin
          cnt_d = cnt_q - 16'd1;
        end else if (sync2_q == IDLE_LEVEL) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DATA;
          cnt_d   = FULL_BIT;
          bit_d   = '0;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      ST_DATA: begin
        if (!mid) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          shift_d = {sync2_q, shift_q[DATA_W-1:1]};
          cnt_d   = FULL_BIT;
          bit_d   = bit_q + 3'd1;
          if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (!mid) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          par_bad_d = ^{shift_q, sync2_q};
          if (^{shift_q, sync2_q} && !clear) parity_err_d = 1'b1;
          state_d = ST_STOP;
          cnt_d   = FULL_BIT;
        end
      end
`endif
      ST_STOP: begin
        if (!mid) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          state_d = ST_IDLE;
          if (sync2_q == IDLE_LEVEL) begin
`ifdef UART_RX_PARITY_EN
            push_d = !par_bad_q;
`else
            push_d = 1'b1;
`endif
          end else begin
            frame_set = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d      = (state_d != ST_IDLE);
    frame_err_d = clear ? 1'b0 : (frame_err_q || frame_set);
    overrun_d   = clear ? 1'b0 : (overrun_q || (push_q && fifo_full && !fifo_pop));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= IDLE_LEVEL;
      sync2_q     <= IDLE_LEVEL;
      prev_q      <= IDLE_LEVEL;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= rx;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_q),
    .pop   (fifo_pop),
    .flush (clear),
    .din   (shift_q),
    .dout  (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: frames are driven bit by bit, the expected FIFO
// contents and sticky flags come from a frame-level model; a monitor checks each pop.
module tb_uart_rx_core;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 8;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  localparam int unsigned LAT_MIN = (NBITS - 1) * CPB + CPB / 2 + 1;
  localparam int unsigned LAT_MAX = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_core #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .clear     (clear),
    .busy      (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [7:0]  exp_q[$];
  logic        exp_frame = 1'b0;
  logic        exp_ovr = 1'b0;
  logic        exp_par = 1'b0;
  int          ready_mode = 0;
  logic        lat_check = 1'b0;
  int unsigned start_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted pop is compared against the head of the expected queue.
  logic       held_v = 1'b0;
  logic [7:0] held_d = '0;
  logic       prev_valid = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v     = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (held_v && rx_valid) check("hold_stable", {24'd0, rx_data}, {24'd0, held_d});
      if (rx_valid && !prev_valid && lat_check) begin
        lat_check = 1'b0;
        vectors++;
        if ((cyc - start_cyc) < LAT_MIN || (cyc - start_cyc) > LAT_MAX) begin
          miscompares++;
          $display("FAIL valid_latency: got %0d cycles expected %0d..%0d", cyc - start_cyc, LAT_MIN, LAT_MAX);
        end
      end
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pop: got %0h expected no data", rx_data);
        end else begin
          check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        end
      end
      held_v     = rx_valid && !rx_ready;
      held_d     = rx_data;
      prev_valid = rx_valid;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       rx_ready = 1'b0;
        1:       rx_ready = 1'($urandom_range(0, 1));
        default: rx_ready = 1'b1;
      endcase
    end
  end

  // Drives one frame; the model decides acceptance before the stop bit so the
  // expected byte is queued ahead of the DUT write.
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_b, input bit keep_low);
    logic accept;
    accept = stop_b;
`ifdef UART_RX_PARITY_EN
    if (par_b != ^b) begin
      accept  = 1'b0;
      exp_par = 1'b1;
    end
`endif
    if (!stop_b) exp_frame = 1'b1;
    start_cyc = cyc;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = par_b;
    tick(CPB);
`endif
    if (accept) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else exp_ovr = 1'b1;
    end
    rx = stop_b;
    tick(CPB);
    if (!keep_low) rx = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b1, ^b, 1'b0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    exp_q.delete();
    exp_frame = 1'b0;
    exp_ovr   = 1'b0;
    exp_par   = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    ready_mode = 2;
    n = 0;
    while ((exp_q.size() != 0 || rx_valid) && n < 100) begin
      tick(1);
      n++;
    end
    check("drain_queue", exp_q.size(), 0);
    check("drain_valid", {31'd0, rx_valid}, 0);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_frame_err"}, {31'd0, frame_err}, {31'd0, exp_frame});
    check({tag, "_overrun"}, {31'd0, overrun}, {31'd0, exp_ovr});
`ifdef UART_RX_PARITY_EN
    check({tag, "_parity_err"}, {31'd0, parity_err}, {31'd0, exp_par});
`endif
  endtask

  initial begin
    tick(3);
    check("reset_valid", {31'd0, rx_valid}, 0);
    check("reset_data", {24'd0, rx_data}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    check_flags("reset");
    rst_n = 1'b1;
    tick(4);

    // Single frame, valid latency measured from the start bit
    ready_mode = 0;
    tick(2);
    lat_check = 1'b1;
    send_good(8'h3D);
    check("single_valid", {31'd0, rx_valid}, 1);
    check("single_data", {24'd0, rx_data}, 32'h3D);
    check_flags("single");
    drain();

    // Short low glitch is rejected in START
    rx = 1'b0;
    tick(5);
    check("glitch_busy_hi", {31'd0, busy}, 1);
    tick(3);
    rx = 1'b1;
    tick(3 * CPB);
    check("glitch_busy_lo", {31'd0, busy}, 0);
    check("glitch_valid", {31'd0, rx_valid}, 0);
    check_flags("glitch");

    // Bad stop bit followed by a break on the line
    send_frame(8'h0F, 1'b0, ^8'h0F, 1'b1);
    tick(3 * CPB);
    check("break_busy", {31'd0, busy}, 0);
    rx = 1'b1;
    tick(CPB);
    check("ferr_valid", {31'd0, rx_valid}, 0);
    check_flags("ferr");
    pulse_clear();
    check_flags("ferr_clr");
    send_good(8'h81);
    drain();

    // Overrun: nine bytes into an eight-deep FIFO with no consumer
    ready_mode = 0;
    tick(2);
    for (int i = 1; i <= 9; i++) send_good(8'(i));
    check_flags("ovr");
    drain();
    pulse_clear();
    check_flags("ovr_clr");

    // Clear flushes queued bytes
    ready_mode = 0;
    tick(2);
    send_good(8'h11);
    send_good(8'h22);
    pulse_clear();
    check("flush_valid", {31'd0, rx_valid}, 0);

    // Reset in the middle of a frame, then a clean frame
    ready_mode = 2;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = (8'hA5 >> i) & 1'b1;
      tick(CPB);
    end
    rst_n = 1'b0;
    rx    = 1'b1;
    tick(3);
    check("rst_mid_busy", {31'd0, busy}, 0);
    check("rst_mid_valid", {31'd0, rx_valid}, 0);
    rst_n = 1'b1;
    tick(CPB);
    check("rst_mid_idle", {31'd0, busy}, 0);
    send_good(8'h5A);
    drain();
    check_flags("rst_mid");

    // Randomized frames with random consumer back-pressure
    ready_mode = 1;
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      logic       s;
      logic       p;
      b = 8'($urandom);
      s = ($urandom_range(0, 7) != 0);
      p = ^b;
`ifdef UART_RX_PARITY_EN
      if ($urandom_range(0, 7) == 0) p = ~p;
`endif
      send_frame(b, s, p, 1'b0);
      check_flags("rand");
      tick($urandom_range(1, 20));
    end
    drain();
    pulse_clear();
    check_flags("rand_clr");

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so parity bit 1 is correct
    ready_mode = 2;
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    tick(4);
    check("par_bad_valid", {31'd0, rx_valid}, 0);
    check_flags("par_bad");
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    drain();
    check_flags("par_good");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
